// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO of any depth >= 2 with occupancy count, programmable
// almost-full/almost-empty thresholds, error pulses and optional FWFT output.
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter int unsigned FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Explicit wrap so non-power-of-two depths never touch unused slots
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A write into a full FIFO is accepted when a read frees the head slot
    always_comb begin
        rd_acc     = rd_en & ~empty;
        wr_acc     = wr_en & (~full | rd_en);
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count_next;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    // Storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (32'(count) >= AF_LEVEL);
    assign almost_empty = (32'(count) <= AE_LEVEL);

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         data_out <= '0;
                else if (rd_acc) data_out <= mem[rd_ptr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: three configurations checked against
// a queue-based reference model, plus directed table and corner sequences.
module tb_sync_fifo_flex;

    localparam int unsigned W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         wr    [3];
    logic         rd    [3];
    logic [W-1:0] din   [3];
    logic [W-1:0] dout  [3];
    logic         full  [3];
    logic         empty [3];
    logic         af    [3];
    logic         ae    [3];
    logic         ovf   [3];
    logic         unf   [3];
    logic [2:0]   cnt5;
    logic [3:0]   cntf;
    logic [3:0]   cntt;

    int unsigned depth_k [3] = '{5, 8, 8};
    int unsigned af_k    [3] = '{4, 7, 6};
    int unsigned ae_k    [3] = '{1, 1, 2};
    bit          fwft_k  [3] = '{1'b0, 1'b1, 1'b0};

    logic [W-1:0] mq       [3][$];
    logic [W-1:0] exp_dout [3];
    bit           exp_ovf  [3];
    bit           exp_unf  [3];

    int n_tests = 0;
    int n_fail  = 0;

    sync_fifo_flex #(.DATA_WIDTH(W), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .wr_en(wr[0]), .data_in(din[0]), .rd_en(rd[0]),
        .data_out(dout[0]), .full(full[0]), .empty(empty[0]), .almost_full(af[0]),
        .almost_empty(ae[0]), .count(cnt5), .overflow(ovf[0]), .underflow(unf[0]));

    sync_fifo_flex #(.DATA_WIDTH(W), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1)) u_f8 (
        .clk(clk), .rst(rst), .wr_en(wr[1]), .data_in(din[1]), .rd_en(rd[1]),
        .data_out(dout[1]), .full(full[1]), .empty(empty[1]), .almost_full(af[1]),
        .almost_empty(ae[1]), .count(cntf), .overflow(ovf[1]), .underflow(unf[1]));

    sync_fifo_flex #(.DATA_WIDTH(W), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_t8 (
        .clk(clk), .rst(rst), .wr_en(wr[2]), .data_in(din[2]), .rd_en(rd[2]),
        .data_out(dout[2]), .full(full[2]), .empty(empty[2]), .almost_full(af[2]),
        .almost_empty(ae[2]), .count(cntt), .overflow(ovf[2]), .underflow(unf[2]));

    typedef struct {
        bit         wr;
        bit         rd;
        logic [W-1:0] din;
        int         cnt;
        logic [W-1:0] dout;
        bit         full;
        bit         empty;
        bit         af;
        bit         ae;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit w, input bit r, input logic [W-1:0] d, input int c,
                       input logic [W-1:0] q, input bit f, input bit e, input bit a_f,
                       input bit a_e, input bit o, input bit u);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.cnt = c; v.dout = q; v.full = f;
        v.empty = e; v.af = a_f; v.ae = a_e; v.ovf = o; v.unf = u;
        tbl.push_back(v);
    endtask

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt5);
            1:       return int'(cntf);
            default: return int'(cntt);
        endcase
    endfunction

    task automatic check(input string name, input int k, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, expv, $time);
        end
    endtask

    // FIFO behaviour expressed as queue operations on the pre-edge state
    task automatic model_step(input int k);
        int sz;
        bit ra;
        bit wa;
        logic [W-1:0] h;
        sz = mq[k].size();
        ra = rd[k] && (sz != 0);
        wa = wr[k] && ((sz != int'(depth_k[k])) || rd[k]);
        exp_ovf[k] = wr[k] && !wa;
        exp_unf[k] = rd[k] && !ra;
        if (ra) begin
            h = mq[k].pop_front();
            if (!fwft_k[k]) exp_dout[k] = h;
        end
        if (wa) mq[k].push_back(din[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            exp_dout[k] = '0;
            exp_ovf[k]  = 1'b0;
            exp_unf[k]  = 1'b0;
        end
    endtask

    task automatic check_dut(input int k);
        int sz;
        sz = mq[k].size();
        check("count", k, cnt_of(k), sz);
        check("empty", k, int'(empty[k]), int'(sz == 0));
        check("full", k, int'(full[k]), int'(sz == int'(depth_k[k])));
        check("almost_full", k, int'(af[k]), int'(sz >= int'(af_k[k])));
        check("almost_empty", k, int'(ae[k]), int'(sz <= int'(ae_k[k])));
        check("overflow", k, int'(ovf[k]), int'(exp_ovf[k]));
        check("underflow", k, int'(unf[k]), int'(exp_unf[k]));
        if (fwft_k[k] && sz != 0)
            check("data_out_head", k, int'(dout[k]), int'(mq[k][0]));
        else if (!fwft_k[k])
            check("data_out", k, int'(dout[k]), int'(exp_dout[k]));
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            wr[k] = 1'b0; rd[k] = 1'b0; din[k] = '0;
        end
    endtask

    task automatic cycle();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        rst = 1'b0;

        // Underflow on an empty FIFO pulses for exactly one cycle
        rd[0] = 1'b1; cycle();
        check("underflow_pulse", 0, int'(unf[0]), 1);
        idle(); cycle();
        check("underflow_clear", 0, int'(unf[0]), 0);

        // Directed DEPTH=5 sequence: fill, overflow, drain, boundary simultaneity, wrap
        add(1,0,6'h2A,1,6'h00,0,0,0,1,0,0);
        add(1,0,6'h15,2,6'h00,0,0,0,0,0,0);
        add(1,0,6'h01,3,6'h00,0,0,0,0,0,0);
        add(1,0,6'h02,4,6'h00,0,0,1,0,0,0);
        add(1,0,6'h04,5,6'h00,1,0,1,0,0,0);
        add(1,0,6'h33,5,6'h00,1,0,1,0,1,0);
        add(0,1,6'h00,4,6'h2A,0,0,1,0,0,0);
        add(0,1,6'h00,3,6'h15,0,0,0,0,0,0);
        add(0,1,6'h00,2,6'h01,0,0,0,0,0,0);
        add(0,1,6'h00,1,6'h02,0,0,0,1,0,0);
        add(0,1,6'h00,0,6'h04,0,1,0,1,0,0);
        add(1,1,6'h11,1,6'h04,0,0,0,1,0,1);
        add(0,1,6'h00,0,6'h11,0,1,0,1,0,0);
        add(1,0,6'h01,1,6'h11,0,0,0,1,0,0);
        add(1,0,6'h02,2,6'h11,0,0,0,0,0,0);
        add(1,0,6'h03,3,6'h11,0,0,0,0,0,0);
        add(1,0,6'h04,4,6'h11,0,0,1,0,0,0);
        add(1,0,6'h05,5,6'h11,1,0,1,0,0,0);
        add(1,1,6'h06,5,6'h01,1,0,1,0,0,0);
        add(0,1,6'h00,4,6'h02,0,0,1,0,0,0);
        add(0,1,6'h00,3,6'h03,0,0,0,0,0,0);
        add(0,1,6'h00,2,6'h04,0,0,0,0,0,0);
        add(0,1,6'h00,1,6'h05,0,0,0,1,0,0);
        add(0,1,6'h00,0,6'h06,0,1,0,1,0,0);
        foreach (tbl[i]) begin
            idle();
            wr[0] = tbl[i].wr; rd[0] = tbl[i].rd; din[0] = tbl[i].din;
            cycle();
            check("tbl_count", i, cnt_of(0), tbl[i].cnt);
            check("tbl_data_out", i, int'(dout[0]), int'(tbl[i].dout));
            check("tbl_full", i, int'(full[0]), int'(tbl[i].full));
            check("tbl_empty", i, int'(empty[0]), int'(tbl[i].empty));
            check("tbl_almost_full", i, int'(af[0]), int'(tbl[i].af));
            check("tbl_almost_empty", i, int'(ae[0]), int'(tbl[i].ae));
            check("tbl_overflow", i, int'(ovf[0]), int'(tbl[i].ovf));
            check("tbl_underflow", i, int'(unf[0]), int'(tbl[i].unf));
        end

        // FWFT: zero-latency head, pop to empty, then streaming at count 1
        idle(); wr[1] = 1'b1; din[1] = 6'h3F; cycle();
        check("fwft_head", 1, int'(dout[1]), 'h3F);
        idle(); rd[1] = 1'b1; cycle();
        check("fwft_pop_empty", 1, int'(empty[1]), 1);
        idle(); wr[1] = 1'b1; din[1] = 6'h21; cycle();
        check("fwft_stream0", 1, int'(dout[1]), 'h21);
        rd[1] = 1'b1; din[1] = 6'h10; cycle();
        check("fwft_stream1", 1, int'(dout[1]), 'h10);
        check("fwft_stream1_cnt", 1, cnt_of(1), 1);
        din[1] = 6'h08; cycle();
        check("fwft_stream2", 1, int'(dout[1]), 'h08);
        check("fwft_stream2_cnt", 1, cnt_of(1), 1);
        idle(); rd[1] = 1'b1; cycle();
        check("fwft_stream_empty", 1, int'(empty[1]), 1);

        // Thresholds AF=6, AE=2 stepped 0..8..0
        for (int i = 1; i <= 8; i++) begin
            idle(); wr[2] = 1'b1; din[2] = W'(i); cycle();
            check("thr_up_af", i, int'(af[2]), int'(i >= 6));
            check("thr_up_ae", i, int'(ae[2]), int'(i <= 2));
        end
        for (int i = 7; i >= 0; i--) begin
            idle(); rd[2] = 1'b1; cycle();
            check("thr_dn_af", i, int'(af[2]), int'(i >= 6));
            check("thr_dn_ae", i, int'(ae[2]), int'(i <= 2));
        end

        // Randomized traffic, first write-biased then read-biased
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                wr[k]  = ($urandom_range(0, 99) < ((c < 300) ? 70 : 35));
                rd[k]  = ($urandom_range(0, 99) < ((c < 300) ? 35 : 70));
                din[k] = W'($urandom);
            end
            cycle();
        end

        // Asynchronous reset mid-cycle with contents present
        idle();
        for (int k = 0; k < 3; k++) begin
            wr[k] = 1'b1; din[k] = W'(k + 9);
        end
        repeat (3) cycle();
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) check_dut(k);
        check("async_rst_dout", 0, int'(dout[0]), 0);
        #1 rst = 1'b0;
        rd[0] = 1'b1; cycle();
        check("post_rst_underflow", 0, int'(unf[0]), 1);
        check("post_rst_count", 0, cnt_of(0), 0);
        idle(); wr[0] = 1'b1; din[0] = 6'h2C; cycle();
        idle(); rd[0] = 1'b1; cycle();
        check("post_rst_data", 0, int'(dout[0]), 'h2C);
        idle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised synchronous FIFO: next generation of the team's binary-depth synchronous FIFO. Supports any depth ≥ 2, including non-power-of-two, with explicit pointer wrap. Adds:
- occupancy count output;
- programmable almost-full and almost-empty thresholds;
- single-cycle overflow and underflow error pulses;
- elaboration-time choice of registered-read or first-word-fall-through (FWFT) output.

It sits between a producer and a consumer in the same clock domain and is the team's default buffering element.

## Interface
Parameters:
- DATA_WIDTH, 6: word width in bits, ≥ 1.
- DEPTH, 8: number of storage words, ≥ 2, any integer.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL. Range 0..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL. Range 0..DEPTH.
- FWFT, 0: 0 selects registered read; 1 selects first-word-fall-through.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read (pop) request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
Storage and pointers:
- Storage is DEPTH words. Memory is not reset.
- wr_ptr and rd_ptr are $clog2(DEPTH) bits wide.
- Each pointer increments on an accepted access and wraps from DEPTH-1 to 0. No power-of-two assumption.
- Occupancy is tracked by a dedicated count register, not by pointer difference.

Acceptance rules, evaluated on the state before the edge:
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_en).
  - When full, a simultaneous read frees one slot, so the write is accepted and count stays DEPTH.
- When empty with wr_en & rd_en: the write is accepted, the read is rejected, and underflow pulses.

Count update: count_next = count + wr_acc - rd_acc.

Errors:
- overflow is registered high for exactly one cycle after any edge where wr_en & !wr_acc.
- underflow is registered high for exactly one cycle after any edge where rd_en & !rd_acc.
- Rejected accesses change no pointer, count or data.

Flags:
- full, empty, almost_full and almost_empty are pure decodes of the count register.
- They therefore change only after a clk edge or on rst.

Read path, FWFT=0:
- data_out is a register loaded with mem[rd_ptr] on an edge where rd_acc is true.
- It holds its value otherwise, including on rejected reads.

Read path, FWFT=1:
- data_out = mem[rd_ptr] combinationally (head word) whenever !empty.
- rd_acc pops the head word.
- data_out value while empty is undefined and not checked.

## Timing
Reset:
- rst asserted forces immediately, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=(AF_LEVEL==0), almost_empty=1, overflow=0, underflow=0.
- data_out is forced to 0 in FWFT=0 mode.
- rst asserted mid-operation discards all contents; the next write after release lands in slot 0.

Latency:
- A write accepted at edge N updates count and empty after edge N.
- FWFT=0: earliest read is at edge N+1, and data_out is valid after edge N+1 (1-cycle read latency).
- FWFT=1: data_out shows the word after edge N with no rd_en needed (0-cycle read latency).

Throughput:
- One write and one read per cycle sustained at any occupancy 1..DEPTH-1.
- At full, sustained only with simultaneous read.

## Test plan
- Reset, DEPTH=5, FWFT=0: pulse rst mid-clock, asynchronously.
  - Expect empty=1, count=0, data_out=0 before the next edge.
  - rd_en for one cycle while empty → underflow high for exactly one cycle, count stays 0.
- Fill to full, DEPTH=5: write 0x2A, 0x15, 0x01, 0x02, 0x04.
  - After the 4th write: almost_full=1.
  - After the 5th write: full=1, count=5.
  - Write 0x33 → overflow pulse, count=5, contents unchanged.
- Drain with wrap, DEPTH=5, FWFT=0: from full, read 5 times.
  - data_out shows 0x2A, 0x15, 0x01, 0x02, 0x04, each one cycle after its rd_en edge.
  - Then empty=1 and almost_empty=1 from count=1.
  - Write 7 more and read 7 more → pointers pass 4→0 and order is preserved.
- Simultaneous at boundaries:
  - Full with wr_en & rd_en → both accepted, count stays 5, no overflow.
  - Empty with wr_en & rd_en → count=1, underflow pulse, written word readable next cycle.
- FWFT=1, DEPTH=8: write 0x3F at edge N.
  - data_out=0x3F after edge N with rd_en low.
  - rd_en at edge N+1 → empty=1.
  - Back-to-back streaming of 0x21, 0x10, 0x08 with rd_en and wr_en both held high → output order matches input order, and count stays at 1.
- Thresholds: AF_LEVEL=6, AE_LEVEL=2, DEPTH=8.
  - Step count 0→8→0 one word at a time.
  - Expect almost_full exactly for count ≥ 6 and almost_empty exactly for count ≤ 2 at every step.
